// File: rtl/st7066u_bus_driver_if.sv
// ---------------------------------------------------------------------------
// st7066u_bus_driver_if
// Bundle between the display sequencer and the ST7066U bus driver.
//   Request side (sequencer -> driver):
//     i_data      request type: 0 = instruction, 1 = character
//     i_e_trigger request strobe; its rising edge is a request
//     i_sel[2:0]  selector
//     i_val[3:0]  value
//   Panel / status side (driver -> pins / sequencer):
//     o_rs, o_rw, o_e, o_db[7:0]  LCD bus
//     o_busy      write cycle in progress
//     o_drop      one-cycle pulse: request discarded
// master = request producer, slave = bus driver.
// ---------------------------------------------------------------------------
interface st7066u_bus_driver_if;
  logic       i_data;
  logic       i_e_trigger;
  logic [2:0] i_sel;
  logic [3:0] i_val;
  logic       o_rs;
  logic       o_rw;
  logic       o_e;
  logic [7:0] o_db;
  logic       o_busy;
  logic       o_drop;

  modport master (
    output i_data, i_e_trigger, i_sel, i_val,
    input  o_rs, o_rw, o_e, o_db, o_busy, o_drop
  );

  modport slave (
    input  i_data, i_e_trigger, i_sel, i_val,
    output o_rs, o_rw, o_e, o_db, o_busy, o_drop
  );
endinterface

// File: rtl/st7066u_bus_driver.sv
// ---------------------------------------------------------------------------
// st7066u_bus_driver
// Turns symbolic sequencer requests into timed 8-bit write cycles on an
// ST7066U character LCD. A request (rising edge of i_e_trigger) is decoded
// into an instruction or character byte, latched onto DB/RS, and E is then
// pulsed: T_AS cycles setup, T_PW cycles E high, T_H cycles hold.
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous, active-high reset
//   bus      st7066u_bus_driver_if.slave (request inputs, LCD pins, status)
// ---------------------------------------------------------------------------
module st7066u_bus_driver #(
  parameter int T_AS = 2,
  parameter int T_PW = 4,
  parameter int T_H  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  st7066u_bus_driver_if.slave         bus
);

  localparam int P_MAX = (T_AS > T_PW) ? ((T_AS > T_H) ? T_AS : T_H)
                                       : ((T_PW > T_H) ? T_PW : T_H);
  // Counter holds (phase length - 1) down to 0.
  localparam int CNT_W = (P_MAX > 1) ? $clog2(P_MAX) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trig_d;
  logic             r_rs;
  logic             r_e;
  logic [7:0]       r_db;
  logic             r_busy;
  logic             r_drop;

  logic             w_req;
  logic             w_valid;
  logic [7:0]       w_byte;

  assign w_req = bus.i_e_trigger & ~r_trig_d;

  // Request decode: instruction table or character glyph.
  always_comb begin
    w_valid = 1'b1;
    w_byte  = 8'h00;
    if (bus.i_data) begin
      // sel[2] is a don't-care for characters.
      unique case (bus.i_sel[1:0])
        2'b00: w_byte = (bus.i_val <= 4'd9) ? (8'h30 + {4'h0, bus.i_val}) : 8'h3F;
        2'b01: w_byte = bus.i_val[0] ? 8'h20 : 8'h3A;
        2'b10: w_byte = 8'h4D;
        2'b11: w_byte = bus.i_val[0] ? 8'h50 : 8'h41;
        default: w_byte = 8'h00;
      endcase
    end else begin
      case (bus.i_sel)
        3'b100:  w_byte = 8'h38;
        3'b101:  w_byte = 8'h0C;
        3'b110:  w_byte = 8'h01;
        3'b111:  w_byte = 8'h06;
        3'b000:  w_byte = 8'h80 | {4'h0, bus.i_val};
        default: w_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      // Reset high so a strobe held through reset is not seen as an edge.
      r_trig_d <= 1'b1;
      r_rs     <= 1'b0;
      r_e      <= 1'b0;
      r_db     <= 8'h00;
      r_busy   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_trig_d <= bus.i_e_trigger;
      r_drop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_valid) begin
              r_db    <= w_byte;
              r_rs    <= bus.i_data;
              r_busy  <= 1'b1;
              r_state <= S_SETUP;
              r_cnt   <= CNT_W'(T_AS - 1);
            end else begin
              r_drop  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_PULSE;
            r_e     <= 1'b1;
            r_cnt   <= CNT_W'(T_PW - 1);
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= S_HOLD;
            r_e     <= 1'b0;
            r_cnt   <= CNT_W'(T_H - 1);
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_e     <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
      // No queueing: anything arriving mid-cycle (even on the final hold
      // cycle) is discarded and flagged.
      if (w_req && (r_state != S_IDLE))
        r_drop <= 1'b1;
    end
  end

  assign bus.o_rs   = r_rs;
  assign bus.o_rw   = 1'b0;
  assign bus.o_e    = r_e;
  assign bus.o_db   = r_db;
  assign bus.o_busy = r_busy;
  assign bus.o_drop = r_drop;

endmodule

// File: tb/tb_st7066u_bus_driver.sv
// ---------------------------------------------------------------------------
// tb_st7066u_bus_driver
// Self-checking bench for st7066u_bus_driver with default timing
// (T_AS=2, T_PW=4, T_H=2): decode table, hand-written corner sequences,
// and randomized requests compared against a reference decoder.
// ---------------------------------------------------------------------------
module tb_st7066u_bus_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  st7066u_bus_driver_if bus ();

  st7066u_bus_driver dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] cur_db;
  logic       cur_rs;

  typedef struct {
    int         busy_n;
    int         busy_first;
    int         e_n;
    int         e_first;
    int         e_pulses;
    int         drops;
    int         rw_bad;
    logic [7:0] db;
    logic       rs;
  } obs_t;

  typedef struct {
    logic       d;
    logic [2:0] s;
    logic [3:0] v;
    logic       ok;
    logic [7:0] db;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference decoder, straight from the request rules.
  function automatic void ref_decode(input logic d, input logic [2:0] s, input logic [3:0] v,
                                     output logic ok, output logic [7:0] b);
    int iv;
    iv = int'(v);
    ok = 1'b1;
    b  = 8'h00;
    if (d) begin
      if (s[1:0] == 2'd0)      b = (iv < 10) ? 8'(48 + iv) : 8'h3F;
      else if (s[1:0] == 2'd1) b = (iv % 2 == 1) ? 8'h20 : 8'h3A;
      else if (s[1:0] == 2'd3) b = (iv % 2 == 1) ? 8'h50 : 8'h41;
      else                     b = 8'h4D;
    end else begin
      case (s)
        3'b100:  b = 8'h38;
        3'b101:  b = 8'h0C;
        3'b110:  b = 8'h01;
        3'b111:  b = 8'h06;
        3'b000:  b = 8'(128 + iv);
        default: ok = 1'b0;
      endcase
    end
  endfunction

  task automatic init_obs(output obs_t o);
    o.busy_n = 0; o.busy_first = -1; o.e_n = 0; o.e_first = -1;
    o.e_pulses = 0; o.drops = 0; o.rw_bad = 0; o.db = 8'h00; o.rs = 1'b0;
  endtask

  task automatic sample(input int k, inout obs_t o, inout logic e_prev);
    if (bus.o_busy === 1'b1) begin o.busy_n++; if (o.busy_first < 0) o.busy_first = k; end
    if (bus.o_e === 1'b1) begin o.e_n++; if (o.e_first < 0) o.e_first = k; end
    if (bus.o_e === 1'b1 && e_prev !== 1'b1) o.e_pulses++;
    e_prev = bus.o_e;
    if (bus.o_drop === 1'b1) o.drops++;
    if (bus.o_rw !== 1'b0) o.rw_bad++;
  endtask

  // One isolated request; inputs are scrambled after the detection cycle.
  task automatic run_req(input logic d, input logic [2:0] s, input logic [3:0] v, output obs_t o);
    logic e_prev;
    e_prev = 1'b0;
    init_obs(o);
    @(negedge clk);
    bus.i_e_trigger = 1'b0;
    @(negedge clk);
    bus.i_data = d; bus.i_sel = s; bus.i_val = v; bus.i_e_trigger = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sample(k, o, e_prev);
      if (k == 1) begin
        bus.i_e_trigger = 1'b0;
        bus.i_data = 1'($urandom); bus.i_sel = 3'($urandom); bus.i_val = 4'($urandom);
      end
    end
    o.db = bus.o_db;
    o.rs = bus.o_rs;
  endtask

  task automatic check_req(input string nm, input logic d, input logic ok,
                           input logic [7:0] exp_db, input obs_t o);
    if (ok) begin
      chk({nm, ".busy_first"}, o.busy_first, 1);
      chk({nm, ".busy_len"},   o.busy_n, 8);
      chk({nm, ".e_first"},    o.e_first, 3);
      chk({nm, ".e_len"},      o.e_n, 4);
      chk({nm, ".drop"},       o.drops, 0);
      chk({nm, ".db"},         o.db, exp_db);
      chk({nm, ".rs"},         o.rs, d);
      cur_db = exp_db;
      cur_rs = d;
    end else begin
      chk({nm, ".drop"},       o.drops, 1);
      chk({nm, ".busy_len"},   o.busy_n, 0);
      chk({nm, ".e_len"},      o.e_n, 0);
      chk({nm, ".db_kept"},    o.db, cur_db);
      chk({nm, ".rs_kept"},    o.rs, cur_rs);
    end
    chk({nm, ".rw"}, o.rw_bad, 0);
  endtask

  // Watchdog: the run must end on its own.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    obs_t o;
    logic e_prev;
    logic ok;
    logic [7:0] b;
    logic d;
    logic [2:0] s;
    logic [3:0] v;

    tbl[0]  = '{1'b0, 3'b100, 4'h0, 1'b1, 8'h38};
    tbl[1]  = '{1'b1, 3'b000, 4'h7, 1'b1, 8'h37};
    tbl[2]  = '{1'b1, 3'b000, 4'hB, 1'b1, 8'h3F};
    tbl[3]  = '{1'b1, 3'b001, 4'h0, 1'b1, 8'h3A};
    tbl[4]  = '{1'b1, 3'b001, 4'h1, 1'b1, 8'h20};
    tbl[5]  = '{1'b1, 3'b011, 4'h1, 1'b1, 8'h50};
    tbl[6]  = '{1'b1, 3'b011, 4'h0, 1'b1, 8'h41};
    tbl[7]  = '{1'b1, 3'b010, 4'h3, 1'b1, 8'h4D};
    tbl[8]  = '{1'b0, 3'b000, 4'h0, 1'b1, 8'h80};
    tbl[9]  = '{1'b0, 3'b010, 4'h5, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 3'b100, 4'h9, 1'b1, 8'h39};
    tbl[11] = '{1'b0, 3'b000, 4'hA, 1'b1, 8'h8A};

    rst = 1'b1;
    bus.i_data = 1'b0; bus.i_sel = 3'b000; bus.i_val = 4'h0; bus.i_e_trigger = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.rs",   bus.o_rs, 0);
    chk("reset.rw",   bus.o_rw, 0);
    chk("reset.e",    bus.o_e, 0);
    chk("reset.db",   bus.o_db, 8'h00);
    chk("reset.busy", bus.o_busy, 0);
    chk("reset.drop", bus.o_drop, 0);
    rst = 1'b0;
    cur_db = 8'h00;
    cur_rs = 1'b0;
    repeat (2) @(negedge clk);

    // Decode table
    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].d, tbl[i].s, tbl[i].v, o);
      check_req($sformatf("vec%0d", i), tbl[i].d, tbl[i].ok, tbl[i].db, o);
    end

    // Collision: second edge three cycles after the first
    init_obs(o); e_prev = 1'b0;
    @(negedge clk); bus.i_e_trigger = 1'b0;
    @(negedge clk); bus.i_data = 1'b1; bus.i_sel = 3'b001; bus.i_val = 4'h0; bus.i_e_trigger = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      sample(k, o, e_prev);
      if (k == 1) bus.i_e_trigger = 1'b0;
      if (k == 3) begin bus.i_data = 1'b0; bus.i_sel = 3'b100; bus.i_e_trigger = 1'b1; end
      if (k == 4) bus.i_e_trigger = 1'b0;
    end
    chk("collide.drops",    o.drops, 1);
    chk("collide.e_pulses", o.e_pulses, 1);
    chk("collide.busy_len", o.busy_n, 8);
    chk("collide.db",       bus.o_db, 8'h3A);
    chk("collide.rs",       bus.o_rs, 1);

    // Request landing on the final hold cycle
    init_obs(o); e_prev = 1'b0;
    @(negedge clk); bus.i_e_trigger = 1'b0;
    @(negedge clk); bus.i_data = 1'b1; bus.i_sel = 3'b011; bus.i_val = 4'h1; bus.i_e_trigger = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      sample(k, o, e_prev);
      if (k == 1) bus.i_e_trigger = 1'b0;
      if (k == 8) begin bus.i_data = 1'b0; bus.i_sel = 3'b100; bus.i_e_trigger = 1'b1; end
      if (k == 9) bus.i_e_trigger = 1'b0;
    end
    chk("lasthold.drops",    o.drops, 1);
    chk("lasthold.e_pulses", o.e_pulses, 1);
    chk("lasthold.busy_len", o.busy_n, 8);
    chk("lasthold.db",       bus.o_db, 8'h50);
    cur_db = 8'h50; cur_rs = 1'b1;

    // Reset during E pulse, strobe held high across release
    @(negedge clk); bus.i_e_trigger = 1'b0;
    @(negedge clk); bus.i_data = 1'b0; bus.i_sel = 3'b110; bus.i_val = 4'h0; bus.i_e_trigger = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstpulse.e_before", bus.o_e, 1);
    rst = 1'b1;
    #1;
    chk("rstpulse.e",    bus.o_e, 0);
    chk("rstpulse.db",   bus.o_db, 8'h00);
    chk("rstpulse.busy", bus.o_busy, 0);
    chk("rstpulse.rs",   bus.o_rs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_db = 8'h00; cur_rs = 1'b0;
    init_obs(o); e_prev = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sample(k, o, e_prev);
    end
    chk("heldstrobe.busy_len", o.busy_n, 0);
    chk("heldstrobe.drops",    o.drops, 0);
    chk("heldstrobe.db",       bus.o_db, 8'h00);
    run_req(1'b1, 3'b000, 4'h9, o);
    check_req("after_rst", 1'b1, 1'b1, 8'h39, o);

    // Randomized requests against the reference decoder
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom);
      s = 3'($urandom_range(0, 7));
      v = 4'($urandom_range(0, 15));
      ref_decode(d, s, v, ok, b);
      run_req(d, s, v, o);
      check_req($sformatf("rand%0d", i), d, ok, b, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
